inv_shift_rows_stream: RTL and testbench

//  Byte-serial InvShiftRows stage for the decryption datapath.
//  - Collects one 16-byte AES state from an 8-bit valid/ready stream.
//  - Re-emits the state as a 16-byte stream in inverse-ShiftRows order.
//  - Sits between the byte-serial InvSubBytes and AddRoundKey stages.
//  - The forward permutation is selectable so the same block can serve encryption-side tests.

---
 rtl/inv_shift_rows_stream.sv | 112 +++++++++++
 tb/tb_inv_shift_rows_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial (Inv)ShiftRows stage: collects a 16-byte AES state from a valid/ready
// stream, then replays it in row-rotated order on a second valid/ready stream.
module inv_shift_rows_stream #(
   parameter bit INVERSE = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_last,
   output logic       o_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_last,
   input  logic       i_ready,
   output logic       o_err
);

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NUM_BYTES = 16;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   buf_q [NUM_BYTES];
   logic                err_q;

   logic                accept;
   logic                emit;
   logic                cnt_end;
   logic [1:0]          row;
   logic [1:0]          col;
   logic [1:0]          src_col;
   logic [CNT_W-1:0]    src_idx;

   assign cnt_end = (cnt_q == CNT_W'(NUM_BYTES - 1));
   assign accept  = i_valid && o_ready;
   assign emit    = o_valid && i_ready;

   // Source byte for the current output position; column arithmetic wraps in 2 bits.
   assign row     = cnt_q[1:0];
   assign col     = cnt_q[3:2];
   assign src_col = INVERSE ? 2'(col - row) : 2'(col + row);
   assign src_idx = {src_col, row};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (i_valid && cnt_end) state_d = S_DRAIN;
         S_DRAIN: if (i_ready && cnt_end) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   // Handshake outputs depend on state only, so no input-to-output handshake path exists.
   always_comb begin
      o_ready = 1'b0;
      o_valid = 1'b0;
      o_last  = 1'b0;
      o_data  = buf_q[src_idx];
      case (state_q)
         S_FILL: begin
            o_ready = 1'b1;
         end
         S_DRAIN: begin
            o_valid = 1'b1;
            o_last  = cnt_end;
         end
         default: begin
            o_ready = 1'b0;
         end
      endcase
   end

   // Counter wraps 15 -> 0 on the final handshake of either phase.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            buf_q[cnt_q] <= i_data;
            if (i_last != cnt_end) begin
               err_q <= 1'b1;
            end
         end
         if (accept || emit) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign o_err = err_q;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream: directed vectors, round trip,
// randomized backpressure, framing error and mid-drain reset against a row-rotation model.
module tb_inv_shift_rows_stream;

   logic       clk;
   logic       rst;
   logic [7:0] idata  [2];
   logic       ival   [2];
   logic       ilast  [2];
   logic       iready [2];
   logic       oready [2];
   logic [7:0] odata  [2];
   logic       ovalid [2];
   logic       olast  [2];
   logic       oerr   [2];

   int checks;
   int failures;
   bit err_exp [2];

   // Unit 0: INVERSE=1, unit 1: INVERSE=0
   inv_shift_rows_stream #(.INVERSE(1'b1)) u_inv (
      .i_clk(clk), .i_rst(rst),
      .i_data(idata[0]), .i_valid(ival[0]), .i_last(ilast[0]), .o_ready(oready[0]),
      .o_data(odata[0]), .o_valid(ovalid[0]), .o_last(olast[0]), .i_ready(iready[0]),
      .o_err(oerr[0])
   );

   inv_shift_rows_stream #(.INVERSE(1'b0)) u_fwd (
      .i_clk(clk), .i_rst(rst),
      .i_data(idata[1]), .i_valid(ival[1]), .i_last(ilast[1]), .o_ready(oready[1]),
      .o_data(odata[1]), .o_valid(ovalid[1]), .o_last(olast[1]), .i_ready(iready[1]),
      .o_err(oerr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // State viewed as a 4x4 matrix s[row][col]; inverse rotates each row right by its index.
   function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
      logic [127:0] t;
      int dc;
      t = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            dc = inv ? (c + r) % 4 : (c - r + 4) % 4;
            t[8*(4*dc + r) +: 8] = s[8*(4*c + r) +: 8];
         end
      end
      return t;
   endfunction

   // Feeds one state to unit u and checks up to 'stop' output bytes; returns at a negedge.
   task automatic run_state(input int u, input logic [127:0] din, input int last_pos,
                            input int vpct, input int rpct, input int stop,
                            input logic [127:0] exp, output logic [127:0] got);
      int  k;
      int  cyc;
      bit  v;
      bit  r;
      got = '0;
      k   = 0;
      cyc = 0;
      while (k < 16 && cyc < 2000) begin
         v         = ($urandom_range(99) < vpct);
         ival[u]   = v;
         idata[u]  = v ? din[8*k +: 8] : 8'($urandom);
         ilast[u]  = v && (k == last_pos);
         iready[u] = 1'($urandom);
         chk($sformatf("u%0d_fill_ready", u), 128'(oready[u]), 128'(1));
         chk($sformatf("u%0d_fill_valid", u), 128'(ovalid[u]), 128'(0));
         chk($sformatf("u%0d_fill_err", u), 128'(oerr[u]), 128'(err_exp[u]));
         @(posedge clk);
         if (v) begin
            if ((k == last_pos) != (k == 15)) err_exp[u] = 1'b1;
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      if (k < 16) chk($sformatf("u%0d_fill_timeout", u), 128'(k), 128'(16));
      k = 0;
      while (k < stop && cyc < 4000) begin
         r         = ($urandom_range(99) < rpct);
         iready[u] = r;
         ival[u]   = 1'($urandom);
         idata[u]  = 8'($urandom);
         ilast[u]  = 1'($urandom);
         chk($sformatf("u%0d_drain_valid", u), 128'(ovalid[u]), 128'(1));
         chk($sformatf("u%0d_drain_ready", u), 128'(oready[u]), 128'(0));
         chk($sformatf("u%0d_drain_data_b%0d", u, k), 128'(odata[u]), 128'(exp[8*k +: 8]));
         chk($sformatf("u%0d_drain_last_b%0d", u, k), 128'(olast[u]), 128'(k == 15));
         chk($sformatf("u%0d_drain_err", u), 128'(oerr[u]), 128'(err_exp[u]));
         got[8*k +: 8] = odata[u];
         @(posedge clk);
         if (r) k++;
         @(negedge clk);
         cyc++;
      end
      if (k < stop) chk($sformatf("u%0d_drain_timeout", u), 128'(k), 128'(stop));
      if (stop == 16) begin
         chk($sformatf("u%0d_idle_ready", u), 128'(oready[u]), 128'(1));
         chk($sformatf("u%0d_idle_valid", u), 128'(ovalid[u]), 128'(0));
      end
      ival[u]   = 1'b0;
      ilast[u]  = 1'b0;
      iready[u] = 1'b0;
   endtask

   logic [127:0] seq_in;
   logic [127:0] seq_inv;
   logic [127:0] seq_fwd;
   logic [127:0] rnd;
   logic [127:0] g1;
   logic [127:0] g2;

   initial begin
      checks   = 0;
      failures = 0;
      seq_in   = 128'h0F0E0D0C0B0A09080706050403020100;
      seq_inv  = 128'h0306090C0F0205080B0E0104070A0D00;
      seq_fwd  = 128'h0B06010C07020D08030E09040F0A0500;
      for (int u = 0; u < 2; u++) begin
         idata[u] = '0; ival[u] = 1'b0; ilast[u] = 1'b0; iready[u] = 1'b0;
         err_exp[u] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d_rst_ready", u), 128'(oready[u]), 128'(1));
         chk($sformatf("u%0d_rst_valid", u), 128'(ovalid[u]), 128'(0));
         chk($sformatf("u%0d_rst_last", u), 128'(olast[u]), 128'(0));
         chk($sformatf("u%0d_rst_data", u), 128'(odata[u]), 128'(0));
         chk($sformatf("u%0d_rst_err", u), 128'(oerr[u]), 128'(0));
      end
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, full throughput
      run_state(0, seq_in, 15, 100, 100, 16, seq_inv, g1);
      run_state(1, seq_in, 15, 100, 100, 16, seq_fwd, g1);

      // Round trip: forward instance feeding the inverse instance
      for (int n = 0; n < 2; n++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         run_state(1, rnd, 15, 100, 100, 16, model(rnd, 1'b0), g1);
         run_state(0, g1, 15, 100, 100, 16, model(g1, 1'b1), g2);
         chk("roundtrip", g2, rnd);
      end

      // Back-to-back states with random gaps and stalls on both units
      for (int n = 0; n < 3; n++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         run_state(0, rnd, 15, 60, 50, 16, model(rnd, 1'b1), g1);
      end
      for (int n = 0; n < 3; n++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         run_state(1, rnd, 15, 70, 40, 16, model(rnd, 1'b0), g1);
      end

      // Misplaced i_last: sticky error, permutation unaffected
      run_state(0, seq_in, 7, 100, 100, 16, seq_inv, g1);
      chk("err_set_after_frame", 128'(oerr[0]), 128'(1));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_state(0, rnd, 15, 80, 80, 16, model(rnd, 1'b1), g1);
      chk("err_persists", 128'(oerr[0]), 128'(1));

      // Reset in the middle of DRAIN after 9 bytes have been taken
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_state(0, rnd, 15, 100, 100, 9, model(rnd, 1'b1), g1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", 128'(ovalid[0]), 128'(0));
      chk("midrst_ready", 128'(oready[0]), 128'(1));
      chk("midrst_last", 128'(olast[0]), 128'(0));
      chk("midrst_err", 128'(oerr[0]), 128'(0));
      err_exp[0] = 1'b0;
      err_exp[1] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_state(0, rnd, 15, 75, 75, 16, model(rnd, 1'b1), g1);
      chk("post_rst_state", g1, model(rnd, 1'b1));
      chk("post_rst_err", 128'(oerr[0]), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
